// File: rtl/voice_allocator.sv
// ---------------------------------------------------------------------------
// voice_allocator
//
// Polyphonic voice allocator for the logic-noise synth. It debounces eight
// active-low note keys and hands each held key to one of NUM_VOICES shared
// oscillator voices. A released key frees its voice. When no voice is free,
// a new press steals the least-recently-allocated voice.
//
// Build option:
//   VOICE_STEAL_EN  defined   -> a press with no free voice steals the oldest
//                               voice.
//                   undefined -> such a press only pulses full_evt. All voices
//                               and ranks stay unchanged, and the dropped key
//                               never sounds.
//
// Parameters:
//   NUM_VOICES     number of shared voices (2..8)
//   DEBOUNCE_BITS  width of the debounce divider; one sample tick every
//                  2^DEBOUNCE_BITS clocks (>= 1)
//
// Ports:
//   clk         system clock
//   rst         asynchronous, active-high reset
//   btn[7:0]    raw note keys, active-low; bit k is note k
//   voice_note  3-bit note index per voice; voice v is at bits [3v+2:3v]
//   voice_gate  1 = voice v is sounding
//   key_held    debounced pressed state per key (active-high)
//   full_evt    one-cycle pulse during a press that finds no free voice
// ---------------------------------------------------------------------------
module voice_allocator #(
  parameter int NUM_VOICES    = 4,
  parameter int DEBOUNCE_BITS = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [7:0]                btn,
  output logic [3*NUM_VOICES-1:0]   voice_note,
  output logic [NUM_VOICES-1:0]     voice_gate,
  output logic [7:0]                key_held,
  output logic                      full_evt
);

  localparam logic [2:0] OLDEST = 3'(NUM_VOICES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REL,
    ST_PRESS
  } state_t;

  // -------------------------------------------------------------------------
  // Input synchronizer and debounce divider
  // -------------------------------------------------------------------------
  logic [7:0]               sync1_q, sync2_q;
  logic [DEBOUNCE_BITS-1:0] div_q;
  logic                     tick;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      div_q   <= '0;
    end else begin
      sync1_q <= ~btn;
      sync2_q <= sync1_q;
      div_q   <= div_q + 1'b1;
    end
  end

  assign tick = (div_q == '0);

  // -------------------------------------------------------------------------
  // Debounce and pending-event masks
  // -------------------------------------------------------------------------
  state_t     state_q;
  logic [2:0] key_q;

  logic [7:0] prev_q, prev_d;
  logic [7:0] held_q, held_d;
  logic [7:0] press_pend_q, press_pend_d;
  logic [7:0] rel_pend_q, rel_pend_d;
  logic [7:0] press_clr, rel_clr;

  // The event being serviced this cycle retires its pending bit.
  assign press_clr = (state_q == ST_PRESS) ? (8'd1 << key_q) : 8'd0;
  assign rel_clr   = (state_q == ST_REL)   ? (8'd1 << key_q) : 8'd0;

  always_comb begin
    prev_d       = prev_q;
    held_d       = held_q;
    // Retire first, so an edge detected in the same cycle as the service of
    // that key starts a fresh pending event instead of being swallowed.
    press_pend_d = press_pend_q & ~press_clr;
    rel_pend_d   = rel_pend_q & ~rel_clr;
    if (tick) begin
      prev_d = sync2_q;
      for (int k = 0; k < 8; k++) begin
        // Two equal consecutive tick samples that disagree with the held
        // state commit a change.
        if ((sync2_q[k] == prev_q[k]) && (sync2_q[k] != held_q[k])) begin
          held_d[k] = sync2_q[k];
          if (sync2_q[k]) begin
            press_pend_d[k] = 1'b1;
          end else if (press_pend_d[k]) begin
            // Press never serviced: the press and release cancel out.
            press_pend_d[k] = 1'b0;
          end else begin
            rel_pend_d[k] = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q       <= '0;
      held_q       <= '0;
      press_pend_q <= '0;
      rel_pend_q   <= '0;
    end else begin
      prev_q       <= prev_d;
      held_q       <= held_d;
      press_pend_q <= press_pend_d;
      rel_pend_q   <= rel_pend_d;
    end
  end

  // -------------------------------------------------------------------------
  // Voice state and press target selection
  // -------------------------------------------------------------------------
  logic [2:0]            note_q [NUM_VOICES];
  logic [2:0]            rank_q [NUM_VOICES];
  logic [NUM_VOICES-1:0] gate_q;
  logic                  full_q;

  logic       free_found;
  logic [2:0] free_idx;
  logic [2:0] oldest_idx;
  logic [2:0] tgt;
  logic [2:0] tgt_rank;
  logic       alloc_en;

  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    oldest_idx = '0;
    tgt_rank   = '0;
    // Walk downwards so the lowest-index free voice wins.
    for (int v = NUM_VOICES - 1; v >= 0; v--) begin
      if (!gate_q[v]) begin
        free_found = 1'b1;
        free_idx   = 3'(v);
      end
    end
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (rank_q[v] == OLDEST) begin
        oldest_idx = 3'(v);
      end
    end
    tgt = free_found ? free_idx : oldest_idx;
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (3'(v) == tgt) begin
        tgt_rank = rank_q[v];
      end
    end
  end

`ifdef VOICE_STEAL_EN
  assign alloc_en = 1'b1;
`else
  assign alloc_en = free_found;
`endif

  // -------------------------------------------------------------------------
  // Event FSM: releases have priority over presses, lowest key first.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      key_q   <= '0;
      full_q  <= 1'b0;
      gate_q  <= '0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        note_q[v] <= '0;
        rank_q[v] <= 3'(v);
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          full_q <= 1'b0;
          if (|rel_pend_q) begin
            key_q   <= lowest8(rel_pend_q);
            state_q <= ST_REL;
          end else if (|press_pend_q) begin
            key_q   <= lowest8(press_pend_q);
            state_q <= ST_PRESS;
            // Voices only change in REL/PRESS, so fullness seen now is the
            // fullness the PRESS cycle will see; registering it here makes
            // full_evt coincide exactly with that PRESS cycle.
            full_q  <= &gate_q;
          end
        end

        ST_REL: begin
          // A stolen voice carries a different note, so a release of a
          // dropped key matches nothing and is a no-op.
          for (int v = 0; v < NUM_VOICES; v++) begin
            if (gate_q[v] && (note_q[v] == key_q)) begin
              gate_q[v] <= 1'b0;
            end
          end
          state_q <= ST_IDLE;
        end

        ST_PRESS: begin
          full_q <= 1'b0;
          // The pending bit can vanish while this press was being latched,
          // when a release landed right behind it; skip the allocation then
          // so no voice is left gated with no release to come.
          if (press_pend_q[key_q] && alloc_en) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
              if (3'(v) == tgt) begin
                note_q[v] <= key_q;
                gate_q[v] <= 1'b1;
                rank_q[v] <= '0;
              end else if (rank_q[v] < tgt_rank) begin
                rank_q[v] <= rank_q[v] + 3'd1;
              end
            end
          end
          state_q <= ST_IDLE;
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  function automatic logic [2:0] lowest8(input logic [7:0] m);
    logic [2:0] r;
    r = '0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) begin
        r = 3'(i);
      end
    end
    return r;
  endfunction

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < NUM_VOICES; gi++) begin : g_note_out
      assign voice_note[3*gi +: 3] = note_q[gi];
    end
  endgenerate

  assign voice_gate = gate_q;
  assign key_held   = held_q;
  assign full_evt   = full_q;

endmodule

// File: tb/tb_voice_allocator.sv
// ---------------------------------------------------------------------------
// tb_voice_allocator
//
// Scoreboard bench. Each key-pattern change is turned into a list of
// expected voice updates by a reference model. The model keeps the voices as
// note/gate arrays and the allocation age as an LRU list. A monitor pops the
// expected results whenever the DUT's voice outputs change or full_evt
// fires. Each event takes two clocks, so the monitor also checks event
// timing relative to the key_held change.
// ---------------------------------------------------------------------------
module tb_voice_allocator;

  localparam int NV = 4;
  localparam int DB = 2;
  localparam int SETTLE = 48;

  logic              clk = 1'b0;
  logic              rst;
  logic [7:0]        btn;
  logic [3*NV-1:0]   voice_note;
  logic [NV-1:0]     voice_gate;
  logic [7:0]        key_held;
  logic              full_evt;

  always #5 clk = ~clk;

  voice_allocator #(.NUM_VOICES(NV), .DEBOUNCE_BITS(DB)) dut (
    .clk        (clk),
    .rst        (rst),
    .btn        (btn),
    .voice_note (voice_note),
    .voice_gate (voice_gate),
    .key_held   (key_held),
    .full_evt   (full_evt)
  );

  int chk = 0;
  int err = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  typedef struct {
    logic [3*NV-1:0] note;
    logic [NV-1:0]   gate;
    bit              full;
    bit              changes;
    int              idx;
  } exp_t;

  exp_t sb[$];

  int         m_note [NV];
  bit         m_gate [NV];
  int         order[$];      // allocation age, oldest first
  logic [7:0] m_held;

  function automatic void model_reset();
    order.delete();
    for (int v = 0; v < NV; v++) begin
      m_note[v] = 0;
      m_gate[v] = 1'b0;
    end
    for (int v = NV - 1; v >= 0; v--) order.push_back(v);
    m_held = '0;
  endfunction

  function automatic exp_t snap(bit full, bit ch, int idx);
    exp_t e;
    e.note = '0;
    e.gate = '0;
    for (int v = 0; v < NV; v++) begin
      e.note[3*v +: 3] = 3'(m_note[v]);
      e.gate[v]        = m_gate[v];
    end
    e.full    = full;
    e.changes = ch;
    e.idx     = idx;
    return e;
  endfunction

  function automatic void model_alloc(int v, int k);
    m_note[v] = k;
    m_gate[v] = 1'b1;
    for (int i = 0; i < order.size(); i++) begin
      if (order[i] == v) begin
        order.delete(i);
        break;
      end
    end
    order.push_back(v);
  endfunction

  function automatic void model_release(int k, int idx);
    bit ch = 1'b0;
    for (int v = 0; v < NV; v++) begin
      if (m_gate[v] && m_note[v] == k) begin
        m_gate[v] = 1'b0;
        ch = 1'b1;
      end
    end
    if (ch) sb.push_back(snap(1'b0, 1'b1, idx));
  endfunction

  function automatic void model_press(int k, int idx);
    int fv = -1;
    for (int v = NV - 1; v >= 0; v--) if (!m_gate[v]) fv = v;
    if (fv >= 0) begin
      model_alloc(fv, k);
      sb.push_back(snap(1'b0, 1'b1, idx));
    end else begin
`ifdef VOICE_STEAL_EN
      model_alloc(order[0], k);
      sb.push_back(snap(1'b1, 1'b1, idx));
`else
      sb.push_back(snap(1'b1, 1'b0, idx));
`endif
    end
  endfunction

  // ---------------- monitor ----------------
  bit              mon_en = 1'b0;
  bit              full_seen = 1'b0;
  int              held_cyc = 0;
  logic [3*NV-1:0] last_note;
  logic [NV-1:0]   last_gate;
  logic [7:0]      last_held;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (key_held != last_held) held_cyc = cyc;
        if (full_evt) begin
          chk++;
          if (sb.size() == 0 || !sb[0].full) begin
            err++;
            $display("FAIL full_evt_unexpected: got 1 required 0 at cycle %0d", cyc);
          end else if (full_seen) begin
            err++;
            $display("FAIL full_evt_width: still 1 on second cycle, required 0 (cycle %0d)", cyc);
          end else if (cyc != held_cyc + 1 + 2 * sb[0].idx) begin
            err++;
            $display("FAIL full_evt_timing: got cycle %0d required %0d",
                     cyc, held_cyc + 1 + 2 * sb[0].idx);
            void'(sb.pop_front());
          end else if (!sb[0].changes) begin
            void'(sb.pop_front());
          end else begin
            full_seen = 1'b1;
          end
        end
        if (voice_note != last_note || voice_gate != last_gate) begin
          chk++;
          if (sb.size() == 0) begin
            err++;
            $display("FAIL voice_unexpected: got note %h gate %b with no event expected (cycle %0d)",
                     voice_note, voice_gate, cyc);
          end else begin
            e = sb.pop_front();
            if (voice_note != e.note || voice_gate != e.gate) begin
              err++;
              $display("FAIL voice_update: got note %h gate %b required note %h gate %b",
                       voice_note, voice_gate, e.note, e.gate);
            end else if (cyc != held_cyc + 2 + 2 * e.idx) begin
              err++;
              $display("FAIL voice_timing: got cycle %0d required %0d",
                       cyc, held_cyc + 2 + 2 * e.idx);
            end else if (e.full && !full_seen) begin
              err++;
              $display("FAIL steal_full_evt: got no full_evt required one before steal");
            end else begin
              $display("event ok: note %h gate %b cycle %0d", voice_note, voice_gate, cyc);
            end
            full_seen = 1'b0;
          end
        end
      end else begin
        full_seen = 1'b0;
      end
      last_note = voice_note;
      last_gate = voice_gate;
      last_held = key_held;
    end
  end

  // ---------------- stimulus ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    chk++;
    if (got !== req) begin
      err++;
      $display("FAIL %s: got %h required %h", name, got, req);
    end
  endtask

  // Move to a new set of pressed keys and wait for everything to settle.
  task automatic apply(input logic [7:0] p);
    logic [7:0] rel;
    logic [7:0] prs;
    int idx;
    rel = m_held & ~p;
    prs = p & ~m_held;
    idx = 0;
    for (int k = 0; k < 8; k++) if (rel[k]) begin model_release(k, idx); idx++; end
    for (int k = 0; k < 8; k++) if (prs[k]) begin model_press(k, idx); idx++; end
    m_held = p;
    @(negedge clk);
    btn = ~p;
    repeat (SETTLE) @(negedge clk);
    $display("keys %b held %b notes %h gates %b", p, key_held, voice_note, voice_gate);
    check("key_held", 32'(key_held), 32'(m_held));
    chk++;
    if (sb.size() != 0) begin
      err++;
      $display("FAIL missing_event: got %0d outstanding required 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    bit seen;
    rst = 1'b1;
    btn = 8'hFF;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_gate", 32'(voice_gate), 32'd0);
    check("reset_note", 32'(voice_note), 32'd0);
    check("reset_held", 32'(key_held), 32'd0);
    check("reset_full", 32'(full_evt), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    mon_en = 1'b1;

    // Single key, then fill all voices, then a fifth press.
    apply(8'h01);
    check("single_key_gate", 32'(voice_gate), 32'b0001);
    check("single_key_note0", 32'(voice_note[2:0]), 32'd0);
    apply(8'h03);
    apply(8'h07);
    apply(8'h0F);
    apply(8'h1F);
`ifdef VOICE_STEAL_EN
    check("steal_notes", 32'(voice_note), 32'({3'd3, 3'd2, 3'd1, 3'd4}));
`else
    check("full_notes", 32'(voice_note), 32'({3'd3, 3'd2, 3'd1, 3'd0}));
`endif
    check("full_gates", 32'(voice_gate), 32'b1111);

    // Release and reuse, then release of the (possibly stolen) key 0.
    apply(8'h1D);
    check("release_gate1", 32'(voice_gate[1]), 32'd0);
    check("release_note1", 32'(voice_note[5:3]), 32'd1);
    apply(8'h3D);
    check("reuse_note1", 32'(voice_note[5:3]), 32'd5);
    apply(8'h3C);

    // Simultaneous presses.
    apply(8'h00);
    apply(8'h44);
    check("simul_notes01", 32'(voice_note[5:0]), 32'({3'd6, 3'd2}));

    // One-clock glitch on key 3 must not register.
    @(negedge clk);
    btn[3] = 1'b0;
    @(negedge clk);
    btn[3] = 1'b1;
    repeat (SETTLE) @(negedge clk);
    check("glitch_held", 32'(key_held), 32'h44);

    // Reset while a press is being serviced.
    apply(8'h00);
    mon_en = 1'b0;
    btn = ~8'h20;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (key_held[5]) seen = 1'b1;
    end
    chk++;
    if (!seen) begin
      err++;
      $display("FAIL press_timeout: got key_held %b required bit 5 set", key_held);
    end
    @(negedge clk);               // FSM now in its PRESS cycle
    rst = 1'b1;
    #1;
    check("rst_mid_gate", 32'(voice_gate), 32'd0);
    check("rst_mid_note", 32'(voice_note), 32'd0);
    check("rst_mid_held", 32'(key_held), 32'd0);
    check("rst_mid_full", 32'(full_evt), 32'd0);
    btn = 8'hFF;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
    sb.delete();
    @(negedge clk);
    mon_en = 1'b1;
    repeat (SETTLE) @(negedge clk);
    check("post_rst_gate", 32'(voice_gate), 32'd0);
    check("post_rst_held", 32'(key_held), 32'd0);

    // Randomized key patterns; the model also tracks ranks from reset.
    for (int n = 0; n < 40; n++) begin
      apply(8'($urandom_range(0, 255)));
    end
    apply(8'h00);

    $display("CHECKS %0d ERRORS %0d", chk, err);
    $finish;
  end

endmodule

// File: doc/voice_allocator.md
# voice_allocator

Polyphonic voice allocator for the logic-noise synth. It debounces eight note keys and assigns each held key to one of `NUM_VOICES` shared oscillator voices. When a key is released, its voice is freed; when no voice is free, the least-recently-allocated voice is stolen. The block sits between the raw button inputs and the oscillator bank: `voice_note` selects each voice's pitch and `voice_gate` gates it into the output mix.

## Interface
- `NUM_VOICES`, default 4: number of shared voices; legal range 2..8.
- `DEBOUNCE_BITS`, default 16: debounce sample tick occurs every 2^DEBOUNCE_BITS clocks; minimum 1.
- `clk`  in  1  system clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `btn`  in  8  note keys, active-low; bit k is note k (0 = C … 7 = C2).
- `voice_note`  out  3*NUM_VOICES  note index per voice; voice v occupies bits [3v+2:3v].
- `voice_gate`  out  NUM_VOICES  1 = voice v is sounding.
- `key_held`  out  8  debounced pressed state per key (active-high).
- `full_evt`  out  1  one-cycle pulse when a press finds no free voice.

## Operation
- **Input path:** 2-flop synchronizer on `~btn`, then a free-running DEBOUNCE_BITS-wide divider; a tick occurs when the divider equals 0.
- **Debounce:** on each tick, the synchronized sample for each key is compared with the previous tick's sample.
  - If they are equal and differ from `key_held[k]`, `key_held[k]` updates.
  - A 0→1 change sets `press_pend[k]`; a 1→0 change sets `rel_pend[k]`.
- **Pending conflicts:** a release change while `press_pend[k]`=1 clears `press_pend[k]` and does not set `rel_pend[k]`. A press while `rel_pend[k]`=1 sets `press_pend[k]`; the release is then handled first.
- **Priority ranks:** each voice holds a rank in 0..NUM_VOICES-1. Ranks always form a permutation; rank NUM_VOICES-1 is the oldest voice.
- **FSM states:** IDLE, REL, PRESS.
- **IDLE:**
  - If any `rel_pend` bit is set, latch the lowest set index and go to REL.
  - Else if any `press_pend` bit is set, latch the lowest set index and go to PRESS.
  - Else stay in IDLE.
- **REL:**
  - Every voice with gate=1 and note equal to the latched key gets gate cleared; its note is retained.
  - If no voice matches (the voice was stolen), there is no change.
  - Clear `rel_pend[key]` and return to IDLE.
- **PRESS:** target is the lowest-index voice with gate=0.
  - If none is free, the target is the voice with rank NUM_VOICES-1 and `full_evt`=1 (see Configuration).
  - Target gets note=key, gate=1, rank 0; every voice whose rank was below the target's old rank has its rank incremented by 1.
  - Clear `press_pend[key]` and return to IDLE.
- Ranks change only in PRESS.

## Timing
- **Reset values:**
  - `voice_gate`=0, `voice_note`=0, `key_held`=0, `full_evt`=0.
  - rank[v]=v, pending masks 0, divider 0, previous samples 0, state IDLE.
- **Latency:**
  - A key edge is committed to `key_held` on the second tick after it reaches the synchronizer output, i.e. 2 clocks of sync plus 1–2 tick periods.
  - The voice outputs change 2 clocks after `key_held` changes: 1 clock IDLE, 1 clock REL/PRESS. The update is registered at the end of the REL/PRESS cycle.
- **Throughput:** one event per 2 clocks. Eight simultaneous presses complete in 16 clocks, well under one tick for DEBOUNCE_BITS≥5.
- **Glitches:** a glitch shorter than one tick period that lands between sample points produces no event.
- **`full_evt`:** asserted exactly during the PRESS cycle that finds no free voice; low otherwise.
- **Reset mid-operation:** asserting `rst` in any state (including REL/PRESS) forces all reset values immediately. Pending events are lost.

## Configuration
- `VOICE_STEAL_EN` defined: a press with no free voice steals the oldest voice, as described in Operation.
- `VOICE_STEAL_EN` undefined:
  - A press with no free voice pulses `full_evt`, clears `press_pend[key]`, and leaves all voices and ranks unchanged.
  - The dropped key later produces no sound; its release is a no-op.

## Test plan
- **Single key:** bench uses DEBOUNCE_BITS=2, NUM_VOICES=4, macro defined. Hold `btn[0]`=0 for 40 clocks → `key_held[0]`=1, then 2 clocks later voice 0 has note=0, gate=1; `full_evt` stays 0.
- **Steal:** press keys 0,1,2,3 in sequence, then key 4 → voice 0 gets note=4, gate=1; `full_evt` is high for exactly 1 clock; voices 1–3 keep notes 1–3.
- **Release and reuse:** after the steal test, release key 1 → voice 1 gate=0, note=1. Then press key 5 → voice 1 gets note=5. Release key 0 (stolen) → no output change.
- **Simultaneous presses:** keys 6 and 2 pressed on the same tick → voice 0 gets note 2, then 2 clocks later voice 1 gets note 6.
- **Glitch and macro off:** a 1-clock low pulse on `btn[3]` between ticks → no event. With `VOICE_STEAL_EN` undefined, a fifth press → `full_evt` pulses and all four voices are unchanged.
- **Reset during PRESS:** assert `rst` during a PRESS cycle → all outputs go to 0 immediately, ranks return to 0..3, and there is no event after `rst` deasserts while keys remain released.
